// File: rtl/cpu_multicycle_if.sv
// Program-load, debug-read and retire/status signals of the multi-cycle core.
interface cpu_multicycle_if #(
    parameter int unsigned IMEM_DEPTH = 256
);
    logic                          prog_we;
    logic [$clog2(IMEM_DEPTH)-1:0] prog_addr;
    logic [31:0]                   prog_data;
    logic [4:0]                    dbg_rs;
    logic [31:0]                   dbg_rdata;
    logic                          retire;
    logic [31:0]                   retire_pc;
    logic                          halted;

    modport master (
        output prog_we, prog_addr, prog_data, dbg_rs,
        input  dbg_rdata, retire, retire_pc, halted
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, dbg_rs,
        output dbg_rdata, retire, retire_pc, halted
    );
endinterface

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing with
// private instruction/data memories, a program-load port and retire/debug taps.
module cpu_multicycle #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    cpu_multicycle_if.slave bus
);
    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
    typedef enum logic [2:0] {C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_ILLEGAL} cls_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_e;

    state_e      state;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] rf   [32];
    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic        retire_q, halted_q;
    logic [31:0] retire_pc_q;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    cls_e        cls;
    alu_op_e     alu_op;
    logic [31:0] imm, op2, alu_res;
    logic        taken;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // Instruction class, ALU operation and immediate decoded from the held ir
    always_comb begin
        cls    = C_ILLEGAL;
        alu_op = ALU_ADD;
        imm    = '0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    cls = C_ALU_R;
                    case (funct3)
                        3'b000:  alu_op = ALU_ADD;
                        3'b001:  alu_op = ALU_SLL;
                        3'b010:  alu_op = ALU_SLT;
                        3'b100:  alu_op = ALU_XOR;
                        3'b101:  alu_op = ALU_SRL;
                        3'b110:  alu_op = ALU_OR;
                        3'b111:  alu_op = ALU_AND;
                        default: cls    = C_ILLEGAL;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    cls    = C_ALU_R;
                    alu_op = ALU_SUB;
                end
            end
            7'b0010011: begin
                imm = {{20{ir[31]}}, ir[31:20]};
                cls = C_ALU_I;
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b010:  alu_op = ALU_SLT;
                    3'b100:  alu_op = ALU_XOR;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    default: cls    = C_ILLEGAL;
                endcase
            end
            7'b0000011: begin
                imm = {{20{ir[31]}}, ir[31:20]};
                if (funct3 == 3'b010) cls = C_LOAD;
            end
            7'b0100011: begin
                imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                if (funct3 == 3'b010) cls = C_STORE;
            end
            7'b1100011: begin
                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                if (funct3 == 3'b000 || funct3 == 3'b001) cls = C_BRANCH;
            end
            7'b1101111: begin
                imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                cls = C_JAL;
            end
            default: cls = C_ILLEGAL;
        endcase
    end

    // ALU on the latched operands; loads/stores reuse the ADD path for address
    always_comb begin
        op2 = (cls == C_ALU_R) ? b : imm;
        case (alu_op)
            ALU_ADD: alu_res = a + op2;
            ALU_SUB: alu_res = a - op2;
            ALU_AND: alu_res = a & op2;
            ALU_OR:  alu_res = a | op2;
            ALU_XOR: alu_res = a ^ op2;
            ALU_SLT: alu_res = {31'b0, $signed(a) < $signed(op2)};
            ALU_SLL: alu_res = a << op2[4:0];
            ALU_SRL: alu_res = a >> op2[4:0];
            default: alu_res = '0;
        endcase
        taken = funct3[0] ? (a != b) : (a == b);
    end

    // Program-load port; a same-cycle fetch of this word still sees the old value
    always_ff @(posedge clk) begin
        if (bus.prog_we) imem[bus.prog_addr] <= bus.prog_data;
    end

    // Store commit; reset returns the FSM to FETCH at once, so a pending store is dropped
    always_ff @(posedge clk) begin
        if (state == S_MEM && cls == C_STORE) dmem[alu_out[DAW+1:2]] <= b;
    end

    // Instruction sequencer; retire/halted are registered on entry to the final state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            alu_out     <= '0;
            mdr         <= '0;
            retire_q    <= 1'b0;
            retire_pc_q <= '0;
            halted_q    <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            retire_q <= 1'b0;
            case (state)
                S_FETCH: begin
                    ir    <= imem[pc[IAW+1:2]];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a           <= rf[rs1];
                    b           <= rf[rs2];
                    retire_pc_q <= pc;
                    if (cls == C_ILLEGAL) begin
                        state    <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state    <= S_EXEC;
                        retire_q <= (cls == C_BRANCH);
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_BRANCH: begin
                            pc    <= taken ? pc + imm : pc + 32'd4;
                            state <= S_FETCH;
                        end
                        C_LOAD: begin
                            alu_out <= alu_res;
                            pc      <= pc + 32'd4;
                            state   <= S_MEM;
                        end
                        C_STORE: begin
                            alu_out  <= alu_res;
                            pc       <= pc + 32'd4;
                            state    <= S_MEM;
                            retire_q <= 1'b1;
                        end
                        C_JAL: begin
                            alu_out  <= pc + 32'd4;
                            pc       <= pc + imm;
                            state    <= S_WB;
                            retire_q <= 1'b1;
                        end
                        default: begin
                            alu_out  <= alu_res;
                            pc       <= pc + 32'd4;
                            state    <= S_WB;
                            retire_q <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (cls == C_LOAD) begin
                        mdr      <= dmem[alu_out[DAW+1:2]];
                        state    <= S_WB;
                        retire_q <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) rf[rd] <= (cls == C_LOAD) ? mdr : alu_out;
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign bus.retire    = retire_q;
    assign bus.retire_pc = retire_pc_q;
    assign bus.halted    = halted_q;
    assign bus.dbg_rdata = (bus.dbg_rs == 5'd0) ? '0 : rf[bus.dbg_rs];
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: small programs with hand-computed retire
// timing, register results and reset behaviour.
module tb_cpu_multicycle;
    logic clk;
    logic rst;

    cpu_multicycle_if #(.IMEM_DEPTH(256)) bus ();

    cpu_multicycle #(
        .IMEM_DEPTH(256),
        .DMEM_DEPTH(256),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int          cyc;
    int          halt_cyc;
    int          ret_cyc [$];
    logic [31:0] ret_pc  [$];

    logic [31:0] prog    [$];
    int          exp_cyc [$];
    logic [31:0] exp_pc  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Instruction encoders
    function automatic logic [31:0] opi(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] opr(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    // Retire/halt log, cycle 1 is the first cycle after reset release
    always @(negedge clk) begin
        if (rst) begin
            cyc      = 0;
            halt_cyc = 0;
        end else begin
            cyc++;
            if (bus.retire) begin
                ret_cyc.push_back(cyc);
                ret_pc.push_back(bus.retire_pc);
            end
            if (bus.halted && halt_cyc == 0) halt_cyc = cyc;
        end
    end

    task automatic load_word(input int idx, input logic [31:0] w);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'(idx);
        bus.prog_data = w;
        @(posedge clk);
        #1 bus.prog_we = 1'b0;
    endtask

    task automatic start_prog();
        rst = 1'b1;
        ret_cyc.delete();
        ret_pc.delete();
        foreach (prog[i]) load_word(i, prog[i]);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic finish_prog(input string tag, input int halt_exp);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.halted) break;
        end
        #1;
        check({tag, "_halted"}, bus.halted, 1);
        check({tag, "_halt_cyc"}, halt_cyc, halt_exp);
        check({tag, "_nretire"}, ret_cyc.size(), exp_cyc.size());
        for (int i = 0; i < exp_cyc.size() && i < ret_cyc.size(); i++) begin
            check($sformatf("%s_ret%0d_cyc", tag, i), ret_cyc[i], exp_cyc[i]);
            check($sformatf("%s_ret%0d_pc", tag, i), ret_pc[i], exp_pc[i]);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        bus.dbg_rs = idx;
        #1 check(tag, bus.dbg_rdata, exp);
    endtask

    initial begin
        rst           = 1'b1;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.dbg_rs    = 5'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_retire", bus.retire, 0);
        check("rst_retire_pc", bus.retire_pc, 0);
        check("rst_halted", bus.halted, 0);
        chk_reg("rst_x1", 5'd1, 0);

        // ALU sequence
        prog    = '{opi(3'b000, 5'd1, 5'd0, 12'd5), opi(3'b000, 5'd2, 5'd0, 12'd7),
                    opr(7'h00, 3'b000, 5'd3, 5'd1, 5'd2), EBREAK};
        exp_cyc = '{4, 8, 12};
        exp_pc  = '{32'h0, 32'h4, 32'h8};
        start_prog();
        finish_prog("alu", 15);
        chk_reg("alu_x1", 5'd1, 5);
        chk_reg("alu_x2", 5'd2, 7);
        chk_reg("alu_x3", 5'd3, 12);

        // Load/store, including an address that aliases word 2
        prog    = '{opi(3'b000, 5'd3, 5'd0, 12'd12), sw(5'd3, 5'd0, 12'd8), lw(5'd4, 5'd0, 12'd8),
                    opi(3'b000, 5'd5, 5'd0, 12'd99), sw(5'd5, 5'd0, 12'd1032), lw(5'd6, 5'd0, 12'd8),
                    EBREAK};
        exp_cyc = '{4, 8, 13, 17, 21, 26};
        exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        start_prog();
        finish_prog("ldst", 29);
        chk_reg("ldst_x4", 5'd4, 12);
        chk_reg("ldst_x6_alias", 5'd6, 99);

        // Branch loop
        prog    = '{opi(3'b000, 5'd1, 5'd0, 12'd3), opi(3'b000, 5'd1, 5'd1, 12'hFFF),
                    br(3'b001, 5'd1, 5'd0, 13'h1FFC), EBREAK};
        exp_cyc = '{4, 8, 11, 15, 18, 22, 25};
        exp_pc  = '{32'h0, 32'h4, 32'h8, 32'h4, 32'h8, 32'h4, 32'h8};
        start_prog();
        finish_prog("loop", 28);
        chk_reg("loop_x1", 5'd1, 0);

        // jal and x0
        prog    = '{opi(3'b000, 5'd0, 5'd0, 12'd9), opi(3'b000, 5'd2, 5'd0, 12'd1),
                    opi(3'b000, 5'd2, 5'd0, 12'd2), opi(3'b000, 5'd2, 5'd0, 12'd3),
                    jal(5'd1, 21'd8), opi(3'b000, 5'd7, 5'd0, 12'd1),
                    opi(3'b000, 5'd8, 5'd0, 12'd5), EBREAK};
        exp_cyc = '{4, 8, 12, 16, 20, 24};
        exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18};
        start_prog();
        finish_prog("jal", 27);
        chk_reg("jal_x1", 5'd1, 32'h14);
        chk_reg("jal_x7_skipped", 5'd7, 0);
        chk_reg("jal_x8", 5'd8, 5);
        chk_reg("jal_x0", 5'd0, 0);

        // Signed compare, shift and logic corners
        prog = '{opi(3'b000, 5'd1, 5'd0, 12'd1), opi(3'b000, 5'd4, 5'd0, 12'd31),
                 opr(7'h00, 3'b001, 5'd3, 5'd1, 5'd4), opr(7'h00, 3'b010, 5'd5, 5'd3, 5'd1),
                 opr(7'h20, 3'b000, 5'd6, 5'd0, 5'd1), opr(7'h00, 3'b101, 5'd7, 5'd3, 5'd4),
                 opr(7'h00, 3'b100, 5'd8, 5'd3, 5'd6), opr(7'h00, 3'b110, 5'd9, 5'd1, 5'd4),
                 opr(7'h00, 3'b111, 5'd10, 5'd6, 5'd4), opi(3'b010, 5'd11, 5'd3, 12'd0),
                 opi(3'b111, 5'd12, 5'd6, 12'h0F0), opi(3'b110, 5'd13, 5'd1, 12'h700),
                 opi(3'b100, 5'd14, 5'd6, 12'hFFF), opr(7'h00, 3'b010, 5'd15, 5'd1, 5'd3),
                 EBREAK};
        exp_cyc.delete();
        exp_pc.delete();
        for (int i = 0; i < 14; i++) begin
            exp_cyc.push_back(4 * (i + 1));
            exp_pc.push_back(32'(4 * i));
        end
        start_prog();
        finish_prog("corner", 59);
        chk_reg("sll_x3", 5'd3, 32'h8000_0000);
        chk_reg("slt_x5", 5'd5, 1);
        chk_reg("sub_x6", 5'd6, 32'hFFFF_FFFF);
        chk_reg("srl_x7", 5'd7, 1);
        chk_reg("xor_x8", 5'd8, 32'h7FFF_FFFF);
        chk_reg("or_x9", 5'd9, 32'h1F);
        chk_reg("and_x10", 5'd10, 32'h1F);
        chk_reg("slti_x11", 5'd11, 1);
        chk_reg("andi_x12", 5'd12, 32'hF0);
        chk_reg("ori_x13", 5'd13, 32'h701);
        chk_reg("xori_x14", 5'd14, 0);
        chk_reg("slt_x15", 5'd15, 0);

        // Seed dmem word 4 with a known value
        prog    = '{opi(3'b000, 5'd3, 5'd0, 12'h055), sw(5'd3, 5'd0, 12'd16), EBREAK};
        exp_cyc = '{4, 8};
        exp_pc  = '{32'h0, 32'h4};
        start_prog();
        finish_prog("seed", 11);

        // Reset in the MEM cycle of a store: the store must be lost
        prog = '{opi(3'b000, 5'd3, 5'd0, 12'd77), sw(5'd3, 5'd0, 12'd16), EBREAK};
        start_prog();
        repeat (7) @(posedge clk);
        #2;
        check("abort_sw_in_mem", bus.retire, 1);
        check("abort_sw_pc", bus.retire_pc, 32'h4);
        rst = 1'b1;
        #1;
        check("abort_retire", bus.retire, 0);
        check("abort_retire_pc", bus.retire_pc, 0);
        check("abort_halted", bus.halted, 0);
        chk_reg("abort_x3", 5'd3, 0);
        load_word(1, lw(5'd4, 5'd0, 12'd16));
        ret_cyc.delete();
        ret_pc.delete();
        exp_cyc = '{4, 9};
        exp_pc  = '{32'h0, 32'h4};
        @(posedge clk);
        #1 rst = 1'b0;
        finish_prog("rerun", 12);
        chk_reg("rerun_x3", 5'd3, 77);
        chk_reg("rerun_x4_nowrite", 5'd4, 32'h55);

        // Reset while halted
        rst = 1'b1;
        #1 check("halt_rst_clears", bus.halted, 0);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
